apb_cfg_master: RTL

APB initiator that converts a simple valid/ready command stream into APB3 transfers toward the I2S_top register banks (Tx at offset 0x00, Rx at 0x10). It replaces bench-driven pclk/paddr/pwdata sequencing with a hardware sequencer that a CPU-less configuration controller or test harness feeds. It returns read data and an error status per command, and it bounds every transfer with a wait-state timeout.

---
 rtl/apb_cfg_master_if.sv | 52 +++++
 rtl/apb_cfg_master.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/apb_cfg_master_if.sv
// -----------------------------------------------------------------------------
// apb_cfg_master_if
//   Bundles the command stream, the response stream and the APB3 bus that
//   apb_cfg_master sits between.
//   Modport master : the sequencer (consumes commands, drives APB, emits rsp).
//   Modport slave  : the environment (offers commands, acts as the APB slave,
//                    receives responses).
// Signals
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command handshake
//   rsp_valid/rsp_rdata/rsp_err/rsp_timeout          : one-cycle response
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB3 bus
// -----------------------------------------------------------------------------
interface apb_cfg_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cfg_master.sv
// -----------------------------------------------------------------------------
// apb_cfg_master
//   Turns a valid/ready command stream into APB3 transfers (IDLE -> SETUP ->
//   ACCESS) and returns one response pulse per command carrying read data and
//   error status. Every ACCESS phase is bounded by TIMEOUT wait-state cycles.
// Ports
//   pclk   : APB/system clock
//   preset : asynchronous, active-high reset
//   bus    : apb_cfg_master_if.master (command, response and APB signals)
// Parameters
//   ADDR_W, DATA_W : address/data widths (must match the interface instance)
//   TIMEOUT        : max ACCESS cycles with pready low before abort (>= 1)
// -----------------------------------------------------------------------------
module apb_cfg_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                 pclk,
  input logic                 preset,
  apb_cfg_master_if.master    bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e            state_q,       state_d;
  logic              psel_q,        psel_d;
  logic              penable_q,     penable_d;
  logic              pwrite_q,      pwrite_d;
  logic [ADDR_W-1:0] paddr_q,       paddr_d;
  logic [DATA_W-1:0] pwdata_q,      pwdata_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              rsp_err_q,     rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;

  // The only combinational output: accepting a command needs no extra cycle,
  // which is what gives back-to-back transfers a 3-cycle period.
  assign bus.cmd_ready = (state_q == ST_IDLE) && !preset;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;           // single-cycle pulse
    rsp_rdata_d   = rsp_rdata_q;    // response fields hold until the next pulse
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (bus.cmd_valid && bus.cmd_ready) begin
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pwrite_d = bus.cmd_write;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end

      ST_ACCESS: begin
        // pready wins over the timeout when both land on the same cycle;
        // pslverr is only meaningful alongside pready.
        if (bus.pready) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_IDLE;
        end else if (wait_cnt_q == CNT_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          // Only reached below CNT_LAST, so the counter can never wrap.
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // NOTE: the APB address/data and response registers are reset too, so the
  // bus shows all-zero values while idle after reset rather than X.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of every other flop, independent of statement order.
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
